// File: rtl/vxe_regio_arb_pkg.sv
// Shared types and constants for the VxEngine register I/O arbiter.
// Channel FSM encoding is fixed so debug tooling can decode o_*_state directly.
package vxe_regio_arb_pkg;

  localparam int NREQ   = 2;
  localparam int IDX_W  = 10;
  localparam int DATA_W = 32;
  localparam int WPAY_W = IDX_W + DATA_W;
  localparam int RPAY_W = IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } ch_state_e;

  // Both requesting: the round-robin pointer wins; otherwise the lone requester.
  function automatic logic rr_pick(input logic [NREQ-1:0] req, input logic ptr);
    return (req[0] && req[1]) ? ptr : req[1];
  endfunction

endpackage

// File: rtl/vxe_regio_arb_if.sv
// Requester-side and register-block-side signals of the register I/O arbiter.
// Handshake: i_*enable is a level request held until the matching one-cycle accept.
interface vxe_regio_arb_if;
  import vxe_regio_arb_pkg::*;

  logic [IDX_W-1:0]  i_rq0_wreg_idx;
  logic [DATA_W-1:0] i_rq0_wdata;
  logic              i_rq0_wenable;
  logic              o_rq0_waccept;
  logic              o_rq0_werror;
  logic [IDX_W-1:0]  i_rq0_rreg_idx;
  logic              i_rq0_renable;
  logic              o_rq0_raccept;
  logic              o_rq0_rerror;
  logic [DATA_W-1:0] o_rq0_rdata;

  logic [IDX_W-1:0]  i_rq1_wreg_idx;
  logic [DATA_W-1:0] i_rq1_wdata;
  logic              i_rq1_wenable;
  logic              o_rq1_waccept;
  logic              o_rq1_werror;
  logic [IDX_W-1:0]  i_rq1_rreg_idx;
  logic              i_rq1_renable;
  logic              o_rq1_raccept;
  logic              o_rq1_rerror;
  logic [DATA_W-1:0] o_rq1_rdata;

  logic [IDX_W-1:0]  o_wreg_idx;
  logic [DATA_W-1:0] o_wdata;
  logic              o_wenable;
  logic              i_waccept;
  logic              i_werror;
  logic [IDX_W-1:0]  o_rreg_idx;
  logic              o_renable;
  logic [DATA_W-1:0] i_rdata;
  logic              i_raccept;
  logic              i_rerror;

  modport slave (
    input  i_rq0_wreg_idx, i_rq0_wdata, i_rq0_wenable, i_rq0_rreg_idx, i_rq0_renable,
    input  i_rq1_wreg_idx, i_rq1_wdata, i_rq1_wenable, i_rq1_rreg_idx, i_rq1_renable,
    output o_rq0_waccept, o_rq0_werror, o_rq0_raccept, o_rq0_rerror, o_rq0_rdata,
    output o_rq1_waccept, o_rq1_werror, o_rq1_raccept, o_rq1_rerror, o_rq1_rdata,
    output o_wreg_idx, o_wdata, o_wenable, o_rreg_idx, o_renable,
    input  i_waccept, i_werror, i_rdata, i_raccept, i_rerror
  );

  modport master (
    output i_rq0_wreg_idx, i_rq0_wdata, i_rq0_wenable, i_rq0_rreg_idx, i_rq0_renable,
    output i_rq1_wreg_idx, i_rq1_wdata, i_rq1_wenable, i_rq1_rreg_idx, i_rq1_renable,
    input  o_rq0_waccept, o_rq0_werror, o_rq0_raccept, o_rq0_rerror, o_rq0_rdata,
    input  o_rq1_waccept, o_rq1_werror, o_rq1_raccept, o_rq1_rerror, o_rq1_rdata,
    input  o_wreg_idx, o_wdata, o_wenable, o_rreg_idx, o_renable,
    output i_waccept, i_werror, i_rdata, i_raccept, i_rerror
  );

endinterface

// File: rtl/vxe_regio_arb_ch.sv
// One arbitrated register channel: round-robin grant, holding register, issue
// watchdog and per-requester response registers. Used for both write and read.
module vxe_regio_arb_ch
  import vxe_regio_arb_pkg::*;
#(
  parameter int PW         = 42,
  parameter int DW         = 32,
  parameter int TMO_W      = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [NREQ-1:0]           i_req,
  input  logic [NREQ-1:0][PW-1:0]   i_payload,
  output logic [PW-1:0]             o_payload,
  output logic                      o_enable,
  input  logic                      i_accept,
  input  logic                      i_error,
  input  logic [DW-1:0]             i_rdata,
  output logic [NREQ-1:0]           o_accept,
  output logic [NREQ-1:0]           o_error,
  output logic [NREQ-1:0][DW-1:0]   o_rdata,
  output ch_state_e                 o_state
);

  localparam bit               TMO_EN   = (TMO_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TMO_CYCLES - 1) : '0;

  ch_state_e                 r_state;
  logic                      r_rr;
  logic                      r_grant;
  logic [PW-1:0]             r_payload;
  logic [TMO_W-1:0]          r_cnt;
  logic                      r_enable;
  logic [NREQ-1:0]           r_accept;
  logic [NREQ-1:0]           r_error;
  logic [NREQ-1:0][DW-1:0]   r_rdata;
  logic                      w_pick;

  always_comb begin
    w_pick = rr_pick(i_req, r_rr);
  end

  // Accept pulses and the downstream enable are registered alongside the state,
  // so they are high exactly in RESP and ISSUE respectively.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_rr      <= 1'b0;
      r_grant   <= 1'b0;
      r_payload <= '0;
      r_cnt     <= '0;
      r_enable  <= 1'b0;
      r_accept  <= '0;
      r_error   <= '0;
      r_rdata   <= '0;
    end else begin
      r_accept <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (|i_req) begin
            r_grant   <= w_pick;
            r_payload <= i_payload[w_pick];
            r_cnt     <= '0;
            r_enable  <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_accept) begin
            r_error[r_grant]  <= i_error;
            r_rdata[r_grant]  <= i_rdata;
            r_accept[r_grant] <= 1'b1;
            r_enable          <= 1'b0;
            r_state           <= ST_RESP;
          end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
            r_error[r_grant]  <= 1'b1;
            r_accept[r_grant] <= 1'b1;
            r_enable          <= 1'b0;
            r_state           <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + TMO_W'(1);
          end
        end
        ST_RESP: begin
          // Spending this cycle outside IDLE keeps a still-held request from re-granting.
          r_rr    <= ~r_grant;
          r_state <= ST_IDLE;
        end
        default: begin
          r_enable <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_payload = r_payload;
  assign o_enable  = r_enable;
  assign o_accept  = r_accept;
  assign o_error   = r_error;
  assign o_rdata   = r_rdata;
  assign o_state   = r_state;

endmodule

// File: rtl/vxe_regio_arb.sv
// Two-requester arbiter in front of the VxEngine register I/O block.
// Write and read channels are independent instances of vxe_regio_arb_ch.
module vxe_regio_arb
  import vxe_regio_arb_pkg::*;
#(
  parameter int TMO_W      = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              nrst,
  vxe_regio_arb_if.slave    io_bus,
  output ch_state_e         o_wr_state,
  output ch_state_e         o_rd_state
);

  logic [NREQ-1:0]              w_wr_req;
  logic [NREQ-1:0][WPAY_W-1:0]  w_wr_pay_in;
  logic [WPAY_W-1:0]            w_wr_pay_out;
  logic [NREQ-1:0]              w_wr_acc;
  logic [NREQ-1:0]              w_wr_err;
  logic [NREQ-1:0][0:0]         w_unused_wr_rdata;

  logic [NREQ-1:0]              w_rd_req;
  logic [NREQ-1:0][RPAY_W-1:0]  w_rd_pay_in;
  logic [RPAY_W-1:0]            w_rd_pay_out;
  logic [NREQ-1:0]              w_rd_acc;
  logic [NREQ-1:0]              w_rd_err;
  logic [NREQ-1:0][DATA_W-1:0]  w_rd_rdata;

  assign w_wr_req       = {io_bus.i_rq1_wenable, io_bus.i_rq0_wenable};
  assign w_wr_pay_in[0] = {io_bus.i_rq0_wreg_idx, io_bus.i_rq0_wdata};
  assign w_wr_pay_in[1] = {io_bus.i_rq1_wreg_idx, io_bus.i_rq1_wdata};

  assign w_rd_req       = {io_bus.i_rq1_renable, io_bus.i_rq0_renable};
  assign w_rd_pay_in[0] = io_bus.i_rq0_rreg_idx;
  assign w_rd_pay_in[1] = io_bus.i_rq1_rreg_idx;

  // The write channel has no response data; its data port is a 1-bit stub.
  vxe_regio_arb_ch #(
    .PW         (WPAY_W),
    .DW         (1),
    .TMO_W      (TMO_W),
    .TMO_CYCLES (TMO_CYCLES)
  ) u_wr_ch (
    .clk       (clk),
    .nrst      (nrst),
    .i_req     (w_wr_req),
    .i_payload (w_wr_pay_in),
    .o_payload (w_wr_pay_out),
    .o_enable  (io_bus.o_wenable),
    .i_accept  (io_bus.i_waccept),
    .i_error   (io_bus.i_werror),
    .i_rdata   (1'b0),
    .o_accept  (w_wr_acc),
    .o_error   (w_wr_err),
    .o_rdata   (w_unused_wr_rdata),
    .o_state   (o_wr_state)
  );

  vxe_regio_arb_ch #(
    .PW         (RPAY_W),
    .DW         (DATA_W),
    .TMO_W      (TMO_W),
    .TMO_CYCLES (TMO_CYCLES)
  ) u_rd_ch (
    .clk       (clk),
    .nrst      (nrst),
    .i_req     (w_rd_req),
    .i_payload (w_rd_pay_in),
    .o_payload (w_rd_pay_out),
    .o_enable  (io_bus.o_renable),
    .i_accept  (io_bus.i_raccept),
    .i_error   (io_bus.i_rerror),
    .i_rdata   (io_bus.i_rdata),
    .o_accept  (w_rd_acc),
    .o_error   (w_rd_err),
    .o_rdata   (w_rd_rdata),
    .o_state   (o_rd_state)
  );

  assign io_bus.o_wreg_idx    = w_wr_pay_out[WPAY_W-1:DATA_W];
  assign io_bus.o_wdata       = w_wr_pay_out[DATA_W-1:0];
  assign io_bus.o_rq0_waccept = w_wr_acc[0];
  assign io_bus.o_rq1_waccept = w_wr_acc[1];
  assign io_bus.o_rq0_werror  = w_wr_err[0];
  assign io_bus.o_rq1_werror  = w_wr_err[1];

  assign io_bus.o_rreg_idx    = w_rd_pay_out;
  assign io_bus.o_rq0_raccept = w_rd_acc[0];
  assign io_bus.o_rq1_raccept = w_rd_acc[1];
  assign io_bus.o_rq0_rerror  = w_rd_err[0];
  assign io_bus.o_rq1_rerror  = w_rd_err[1];
  assign io_bus.o_rq0_rdata   = w_rd_rdata[0];
  assign io_bus.o_rq1_rdata   = w_rd_rdata[1];

endmodule
